// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: datapath widths, opcode field
// position, fetch FSM encoding and the default reset vector.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word and its pc+4, holds otherwise,
// and a flush only invalidates the entry (flush wins over load).
module if_id_reg
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc4_o
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc4_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads, buffers one word when decode
// stalls, and retires in-flight reads that a branch made stale.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  output logic             if_id_valid,
  output logic [XLEN-1:0]  if_id_instr,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic [OPC_W-1:0] opcode
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;

  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_instr_in;
  logic [XLEN-1:0] ifid_pc4_in;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = word_align(branch_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // NOTE: every signal gets a hold/idle default before the case so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_addr_d   = drop_addr_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    ifid_load     = 1'b0;
    ifid_flush    = branch_taken;
    ifid_instr_in = imem_rdata;
    ifid_pc4_in   = pc_plus4;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (branch_taken) pc_d = redirect_pc;
      end
      ST_REQ: begin
        if (branch_taken) begin
          pc_d = redirect_pc;
          // The memory still owes us this read; remember where it went.
          if (!imem_ack) begin
            drop_addr_d = pc_q;
            state_d     = ST_DROP;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (stall && if_id_valid) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          pc_d         = redirect_pc;
          skid_instr_d = '0;
          skid_pc4_d   = '0;
          state_d      = ST_REQ;
        end else if (!stall) begin
          ifid_load     = 1'b1;
          ifid_instr_in = skid_instr_q;
          ifid_pc4_in   = skid_pc4_q;
          state_d       = ST_REQ;
        end
      end
      ST_DROP: begin
        if (branch_taken) pc_d = redirect_pc;
        if (imem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    case (state_q)
      ST_REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end
      ST_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = '0;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (ifid_instr_in),
    .pc4_i   (ifid_pc4_in),
    .valid_o (if_id_valid),
    .instr_o (if_id_instr),
    .pc4_o   (if_id_pc4)
  );

  assign opcode = if_id_valid ? if_id_instr[OPC_HI:OPC_LO] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run, all compared
// against a behavioural fetch model kept here.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;

  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc4;
  logic [5:0]  opcode;

  logic        imem_req_w, if_id_valid_w;
  logic [31:0] imem_addr_w, if_id_instr_w, if_id_pc4_w;
  logic [5:0]  opcode_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .opcode(opcode)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_valid(if_id_valid_w), .if_id_instr(if_id_instr_w), .if_id_pc4(if_id_pc4_w),
    .opcode(opcode_w)
  );

  // Reference model of the default-parameter instance (RESET_PC = 0).
  bit          m_fresh;      // just out of reset, no request issued yet
  bit          m_skid_full;  // a word is parked waiting for decode
  bit          m_stale;      // a read abandoned by a branch is still owed
  bit          m_v;
  logic [31:0] m_pc, m_stale_addr, m_skid_instr, m_skid_pc4, m_instr, m_pc4;

  task automatic model_reset();
    m_fresh = 1'b1; m_skid_full = 1'b0; m_stale = 1'b0; m_v = 1'b0;
    m_pc = 32'h0; m_stale_addr = '0; m_skid_instr = '0; m_skid_pc4 = '0;
    m_instr = '0; m_pc4 = '0;
  endtask

  task automatic model_step(input bit ack, input logic [31:0] rd, input bit st,
                            input bit br, input logic [31:0] tgt);
    logic [31:0] t;
    t = tgt & 32'hFFFF_FFFC;
    if (br) begin
      m_v = 1'b0;
      if (m_fresh) m_fresh = 1'b0;
      else if (m_skid_full) m_skid_full = 1'b0;
      else if (m_stale) begin if (ack) m_stale = 1'b0; end
      else if (!ack) begin m_stale = 1'b1; m_stale_addr = m_pc; end
      m_pc = t;
    end else if (m_fresh) begin
      m_fresh = 1'b0;
    end else if (m_skid_full) begin
      if (!st) begin
        m_v = 1'b1; m_instr = m_skid_instr; m_pc4 = m_skid_pc4; m_skid_full = 1'b0;
      end
    end else if (m_stale) begin
      if (ack) m_stale = 1'b0;
    end else if (ack) begin
      if (st && m_v) begin
        m_skid_full = 1'b1; m_skid_instr = rd; m_skid_pc4 = m_pc + 32'd4;
      end else begin
        m_v = 1'b1; m_instr = rd; m_pc4 = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Drive one cycle from a falling edge, advance the model, compare at the next falling edge.
  task automatic cycle(input bit ack, input logic [31:0] rd, input bit st,
                       input bit br, input logic [31:0] tgt);
    bit          e_req;
    logic [31:0] e_addr;
    logic [5:0]  e_opc;
    imem_ack = ack; imem_rdata = rd; stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    model_step(ack, rd, st, br, tgt);
    @(negedge clk);
    e_req  = !m_fresh && !m_skid_full;
    e_addr = !e_req ? 32'h0 : (m_stale ? m_stale_addr : m_pc);
    e_opc  = m_v ? m_instr[31:26] : 6'h00;
    n_checks++;
    if (imem_req !== e_req || imem_addr !== e_addr || if_id_valid !== m_v ||
        opcode !== e_opc || (m_v && (if_id_instr !== m_instr || if_id_pc4 !== m_pc4))) begin
      n_errors++;
      $display("FAIL model t=%0t req %b exp %b addr %h exp %h valid %b exp %b instr %h exp %h pc4 %h exp %h opc %h exp %h",
               $time, imem_req, e_req, imem_addr, e_addr, if_id_valid, m_v,
               if_id_instr, m_instr, if_id_pc4, m_pc4, opcode, e_opc);
    end
  endtask

  // Assert reset mid-cycle, check outputs clear without a clock edge, release on a falling edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4, opcode} !== '0 ||
        imem_req_w !== 1'b0 || if_id_valid_w !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_async_clear req %b addr %h valid %b instr %h pc4 %h opc %h, all required 0",
               tag, imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4, opcode);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset("reset");
    n_checks++;
    if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle req %b valid %b required 0 0", imem_req, if_id_valid);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        n_errors++;
        $display("FAIL seq_addr%0d req %b addr %h required 1 %h", i, imem_req, imem_addr, 32'(4 * i));
      end
      w = $urandom;
      cycle(1'b1, w, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'(4 * i + 4) || if_id_instr !== w) begin
        n_errors++;
        $display("FAIL seq_ifid%0d valid %b pc4 %h instr %h required 1 %h %h",
                 i, if_id_valid, if_id_pc4, if_id_instr, 32'(4 * i + 4), w);
      end
    end
  endtask

  task automatic test_stall_skid();
    cycle(1'b1, 32'h8C22_0004, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 32'hAC22_0008, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (imem_req !== 1'b0 || if_id_instr !== 32'h8C22_0004 || opcode !== 6'h23) begin
      n_errors++;
      $display("FAIL stall_hold req %b instr %h opc %h required 0 8c220004 23", imem_req, if_id_instr, opcode);
    end
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (if_id_instr !== 32'hAC22_0008 || opcode !== 6'h2B || if_id_pc4 !== 32'h18 || imem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release instr %h opc %h pc4 %h req %b required ac220008 2b 18 1",
               if_id_instr, opcode, if_id_pc4, imem_req);
    end
  endtask

  task automatic test_branch_drop();
    @(negedge clk);
    do_reset("drop");
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_id_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_enter req %b addr %h valid %b required 1 10 0", imem_req, imem_addr, if_id_valid);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h10) begin
      n_errors++;
      $display("FAIL drop_wait addr %h required 10", imem_addr);
    end
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h40 || if_id_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_exit addr %h valid %b required 40 0", imem_addr, if_id_valid);
    end
  endtask

  task automatic test_branch_ack();
    cycle(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h103);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL branch_ack req %b addr %h valid %b required 1 100 0", imem_req, imem_addr, if_id_valid);
    end
    cycle(1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'h2001_0005 || if_id_pc4 !== 32'h104 || opcode !== 6'h08) begin
      n_errors++;
      $display("FAIL branch_target_fetch valid %b instr %h pc4 %h opc %h required 1 20010005 104 08",
               if_id_valid, if_id_instr, if_id_pc4, opcode);
    end
  endtask

  task automatic test_reset_in_drop();
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
      n_errors++;
      $display("FAIL rst_drop_setup req %b addr %h required 1 104", imem_req, imem_addr);
    end
    do_reset("rst_drop");
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_drop_restart req %b addr %h required 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    @(negedge clk);
    do_reset("wrap");
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (imem_req_w !== 1'b1 || imem_addr_w !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_first req %b addr %h required 1 fffffffc", imem_req_w, imem_addr_w);
    end
    w = 32'h8C00_0000 | ($urandom & 32'h03FF_FFFF);
    cycle(1'b1, w, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (if_id_pc4_w !== 32'h0 || imem_addr_w !== 32'h0 || if_id_instr_w !== w || opcode_w !== 6'h23) begin
      n_errors++;
      $display("FAIL wrap_pc4 pc4 %h addr %h instr %h opc %h required 0 0 %h 23",
               if_id_pc4_w, imem_addr_w, if_id_instr_w, opcode_w, w);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_skid();
    test_branch_drop();
    test_branch_ack();
    test_reset_in_drop();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
